// File: rtl/seq_det_pkg.sv
// Shared constants and enumerations for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int                     DEFAULT_LEN     = 7;
    localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 7'b1000001;

    typedef enum logic {
        MODE_NON_OVL = 1'b0,
        MODE_OVL     = 1'b1
    } mode_e;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear that coincides with an increment leaves the count at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = W'(inc);
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial framing-word detector with reloadable pattern, selectable overlap and match counter.
//   state  | meaning
//   S_FILL | fewer than LEN-1 valid bits held in history, no match possible
//   S_RUN  | history full, next valid bit can complete a match
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = DEFAULT_LEN,
    parameter logic [LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam int             FILL_W    = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LEN - 1);

    state_e            state_q, state_d;
    logic [LEN-1:0]    pat_q, pat_d;
    logic [LEN-2:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q, out_d;
    logic [LEN-1:0]    word;
    logic              hit;

    // Candidate word: history with the incoming bit appended as the newest (LSB).
    assign word = {hist_q, in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = word[LEN-2:0];
            if (hit && (mode_e'(overlap) == MODE_NON_OVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_LAST) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
        state_d = (fill_d == FILL_LAST) ? S_RUN : S_FILL;
    end

    always_comb begin
        hit   = in_valid && !pat_load && (state_q == S_RUN) && (word == pat_q);
        out_d = hit;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (hit),
        .cnt   (match_count)
    );

    assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares each cycle.
module tb_seq_detector_param;

    localparam int LEN   = 7;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in;
    logic             in_valid;
    logic             overlap;
    logic             pat_load;
    logic [LEN-1:0]   pat_in;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_count;

    typedef struct {
        logic             eo;
        logic [CNT_W-1:0] ec;
        string            tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] expc;

    always #5 clk = ~clk;

    seq_detector_param #(
        .LEN     (LEN),
        .PATTERN (7'b1000001),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .match_count (match_count)
    );

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out !== e.eo) begin
                    errors++;
                    $display("FAIL %s out: got %b expected %b", e.tag, out, e.eo);
                end
                checks++;
                if (match_count !== e.ec) begin
                    errors++;
                    $display("FAIL %s match_count: got %0d expected %0d", e.tag, match_count, e.ec);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic b, input logic ld,
                       input logic clr, input logic [LEN-1:0] p,
                       input logic eo, input logic [CNT_W-1:0] ec, input string tag);
        exp_t e;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        in       = b;
        pat_load = ld;
        cnt_clr  = clr;
        pat_in   = p;
        @(posedge clk);
        e.eo  = eo;
        e.ec  = ec;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, tag);
        expc = '0;
    endtask

    task automatic bit_in(input logic b, input logic eo, input logic [CNT_W-1:0] ec, input string tag);
        cyc(1'b0, 1'b1, b, 1'b0, 1'b0, '0, eo, ec, tag);
    endtask

    // Sends bits s[12] first; a gap of idle cycles is inserted after bit number gap_after.
    task automatic send_stream(input logic [12:0] s, input logic [12:0] eo_v,
                               input int gap_after, input int gap_len, input string tag);
        for (int k = 1; k <= 13; k++) begin
            if (eo_v[13-k]) expc = expc + 1'b1;
            bit_in(s[13-k], eo_v[13-k], expc, $sformatf("%s bit%0d", tag, k));
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, expc, $sformatf("%s gap%0d", tag, g));
                end
            end
        end
    endtask

    initial begin : stim
        reset    = 1'b1;
        in       = 1'b0;
        in_valid = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = '0;
        cnt_clr  = 1'b0;
        expc     = '0;

        do_reset("reset0");

        overlap = 1'b1;
        send_stream(13'b1000001000001, 13'b0000001000001, 0, 0, "t1ovl");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd2, "t1 idle");

        do_reset("reset1");
        overlap = 1'b0;
        send_stream(13'b1000001000001, 13'b0000001000000, 0, 0, "t2nonovl");

        do_reset("reset2");
        overlap = 1'b1;
        send_stream(13'b1000001000001, 13'b0000001000001, 4, 3, "t3gap");

        do_reset("reset3");
        overlap = 1'b1;
        for (int k = 0; k < 6; k++) bit_in(1'b1, 1'b0, 2'd0, "t4 pre-ones");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1111111, 1'b0, 2'd0, "t4 load");
        for (int k = 0; k < 6; k++) bit_in(1'b1, 1'b0, 2'd0, "t4 fill-ones");
        bit_in(1'b1, 1'b1, 2'd1, "t4 7th one");
        bit_in(1'b1, 1'b1, 2'd2, "t4 8th one");
        bit_in(1'b1, 1'b1, 2'd3, "t4 9th one");
        bit_in(1'b1, 1'b1, 2'd3, "t5 saturate");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, 1'b1, 2'd1, "t5 clr+hit");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd1, "t5 idle");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 2'd0, "t5 clr alone");
        bit_in(1'b1, 1'b1, 2'd1, "t5 hit after clr");
        bit_in(1'b0, 1'b0, 2'd1, "t5 zero in run");

        // Ones pattern with non-overlap: a hit restarts the fill, seven fresh ones needed.
        for (int k = 0; k < 6; k++) bit_in(1'b1, 1'b0, 2'd1, "t5 ones before nonovl");
        overlap = 1'b0;
        bit_in(1'b1, 1'b1, 2'd2, "t5 nonovl hit");
        for (int k = 0; k < 6; k++) bit_in(1'b1, 1'b0, 2'd2, "t5 nonovl refill");
        bit_in(1'b1, 1'b1, 2'd3, "t5 nonovl 2nd hit");

        do_reset("reset4");
        overlap = 1'b1;
        bit_in(1'b1, 1'b0, 2'd0, "t6 b1");
        bit_in(1'b0, 1'b0, 2'd0, "t6 b2");
        bit_in(1'b0, 1'b0, 2'd0, "t6 b3");
        bit_in(1'b0, 1'b0, 2'd0, "t6 b4");
        bit_in(1'b0, 1'b0, 2'd0, "t6 b5");
        do_reset("t6 midreset");
        bit_in(1'b0, 1'b0, 2'd0, "t6 b6");
        bit_in(1'b1, 1'b0, 2'd0, "t6 b7");

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
